hv_dac_sequencer: RTL and testbench

HV_DAC_SEQUENCER -- requirements
Module: hv_dac_sequencer

---
 rtl/hv_dac_sequencer_if.sv | 19 +
 rtl/hv_dac_sequencer.sv | 160 ++++++++++++++++
 tb/tb_hv_dac_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hv_dac_sequencer_if.sv
// Request/response handshake between the HV DAC sequencer and the I2C byte engine.
interface hv_dac_sequencer_if;
  logic        i2c_req_o;
  logic [1:0]  i2c_line_o;
  logic [15:0] i2c_cmd_o;
  logic [15:0] i2c_data_o;
  logic        i2c_busy_i;
  logic        i2c_done_i;

  modport master (
    output i2c_req_o, i2c_line_o, i2c_cmd_o, i2c_data_o,
    input  i2c_busy_i, i2c_done_i
  );

  modport slave (
    input  i2c_req_o, i2c_line_o, i2c_cmd_o, i2c_data_o,
    output i2c_busy_i, i2c_done_i
  );
endinterface

// File: rtl/hv_dac_sequencer.sv
// HV DAC ramp generator plus a round-robin I2C refresh of the threshold DACs and the HV DAC.
//
// state | meaning
// IDLE  | post-reset, one cycle before the first slot
// LOAD  | snapshot line/cmd/data of the current slot
// REQ   | request held until the engine reports busy
// WAIT  | engine running, waiting for done
// GAPW  | inter-transaction idle, then advance slot
module hv_dac_sequencer #(
  parameter int NCH = 2,
  parameter int DW  = 12,
  parameter int RW  = 16,
  parameter int GAP = 64,
  parameter int TMO = 65535
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [DW-1:0]              hv_target_i,
  input  logic [DW-1:0]              hv_limit_i,
  input  logic [RW-1:0]              ramp_period_i,
  input  logic [NCH*DW-1:0]          thr_i,
  input  logic [2:0]                 eeprom_sel_i,
  hv_dac_sequencer_if.master         i2c,
  output logic [DW-1:0]              hv_current_o,
  output logic                       at_target_o,
  output logic                       i2c_fault_o,
  output logic [$clog2(NCH+1)-1:0]   slot_o
);

  localparam int SW = $clog2(NCH+1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TW-1:0] TMO_LD = TW'((TMO > 0) ? TMO - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GAPW = 3'd4;

  logic [2:0]    state;
  logic [RW-1:0] ramp_cnt;
  logic [RW-1:0] period_m1;
  logic [DW-1:0] lim_cap;
  logic [DW-1:0] eff;
  logic          ramp_wrap;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    ld_addr;
  logic [DW-1:0] ld_code;
  logic [1:0]    ld_line;
  logic [15:0]   ld_data;

  // Effective target: clipped one below the hard limit, forced to 0 when disabled.
  always_comb begin
    lim_cap   = (hv_limit_i == '0) ? '0 : hv_limit_i - 1'b1;
    eff       = '0;
    if (enable_i)
      eff = (hv_target_i < lim_cap) ? hv_target_i : lim_cap;
    period_m1 = (ramp_period_i == '0) ? '0 : ramp_period_i - 1'b1;
  end

  // >= so a shortened period wraps immediately instead of running to overflow.
  assign ramp_wrap = (ramp_cnt >= period_m1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ramp_cnt     <= '0;
      hv_current_o <= '0;
    end else if (ramp_wrap) begin
      ramp_cnt <= '0;
      if (hv_current_o > lim_cap)
        hv_current_o <= lim_cap;
      else if (hv_current_o < eff)
        hv_current_o <= hv_current_o + 1'b1;
      else if (hv_current_o > eff)
        hv_current_o <= hv_current_o - 1'b1;
    end else begin
      ramp_cnt <= ramp_cnt + 1'b1;
    end
  end

  assign at_target_o = !rst_i && (hv_current_o == eff);

  // Slot NCH is the HV DAC itself; lower slots are the threshold channels.
  always_comb begin
    ld_addr = 8'hC0;
    ld_code = hv_current_o;
    ld_line = 2'd2;
    for (int k = 0; k < NCH; k++) begin
      if (int'(slot_o) == k) begin
        ld_addr = 8'hC0 + 8'(2 * k);
        ld_code = thr_i[k*DW +: DW];
        ld_line = 2'd1;
      end
    end
    ld_data = 16'(ld_code) << (16 - DW);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      slot_o         <= '0;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      i2c_fault_o    <= 1'b0;
      i2c.i2c_req_o  <= 1'b0;
      i2c.i2c_line_o <= '0;
      i2c.i2c_cmd_o  <= '0;
      i2c.i2c_data_o <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_LOAD;
        S_LOAD: begin
          i2c.i2c_line_o <= ld_line;
          i2c.i2c_cmd_o  <= {ld_addr, eeprom_sel_i, 5'b0};
          i2c.i2c_data_o <= ld_data;
          i2c.i2c_req_o  <= 1'b1;
          tmo_cnt        <= TMO_LD;
          gap_cnt        <= GAP_LD;
          state          <= S_REQ;
        end
        S_REQ: begin
          if (i2c.i2c_busy_i) begin
            i2c.i2c_req_o <= 1'b0;
            state         <= i2c.i2c_done_i ? S_GAPW : S_WAIT;
          end else if (tmo_cnt == '0) begin
            i2c.i2c_req_o <= 1'b0;
            i2c_fault_o   <= 1'b1;
            state         <= S_GAPW;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (i2c.i2c_done_i) begin
            state <= S_GAPW;
          end else if (tmo_cnt == '0) begin
            i2c_fault_o <= 1'b1;
            state       <= S_GAPW;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_GAPW: begin
          if (gap_cnt == '0) begin
            slot_o <= (slot_o == SW'(NCH)) ? '0 : slot_o + 1'b1;
            state  <= S_LOAD;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hv_dac_sequencer.sv
// Directed bench for hv_dac_sequencer: slot order, ramp, saturation, timeout, reset.
module tb_hv_dac_sequencer;
  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int RW  = 16;
  localparam int GAP = 8;
  localparam int TMO = 40;

  logic              clk_i;
  logic              rst_i;
  logic              enable_i;
  logic [DW-1:0]     hv_target_i;
  logic [DW-1:0]     hv_limit_i;
  logic [RW-1:0]     ramp_period_i;
  logic [NCH*DW-1:0] thr_i;
  logic [2:0]        eeprom_sel_i;
  logic [DW-1:0]     hv_current_o;
  logic              at_target_o;
  logic              i2c_fault_o;
  logic [1:0]        slot_o;

  logic eng_on, eng_busy, eng_done, inj_done;
  int   eng_cnt;
  int   vectors = 0;
  int   miscompares = 0;
  bit   ok;

  logic [15:0] exp_slot [4];
  logic [15:0] exp_line [4];
  logic [15:0] exp_cmd  [4];
  logic [15:0] exp_data [4];

  hv_dac_sequencer_if i2c();
  assign i2c.i2c_busy_i = eng_busy;
  assign i2c.i2c_done_i = eng_done | inj_done;

  hv_dac_sequencer #(.NCH(NCH), .DW(DW), .RW(RW), .GAP(GAP), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .hv_target_i(hv_target_i), .hv_limit_i(hv_limit_i),
    .ramp_period_i(ramp_period_i), .thr_i(thr_i), .eeprom_sel_i(eeprom_sel_i),
    .i2c(i2c), .hv_current_o(hv_current_o), .at_target_o(at_target_o),
    .i2c_fault_o(i2c_fault_o), .slot_o(slot_o)
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  // Engine model: busy two cycles after the request, done pulse twenty cycles after it.
  initial begin
    eng_cnt = 0; eng_busy = 0; eng_done = 0;
    forever begin
      @(negedge clk_i);
      if (!eng_on || rst_i) begin
        eng_cnt = 0; eng_busy = 0; eng_done = 0;
      end else if (eng_cnt == 0) begin
        eng_done = 0;
        if (i2c.i2c_req_o) eng_cnt = 1;
      end else begin
        eng_cnt++;
        eng_busy = (eng_cnt >= 2 && eng_cnt < 20);
        eng_done = (eng_cnt == 20);
        if (eng_cnt == 20) eng_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wait_req(output bit found);
    logic prev;
    prev  = i2c.i2c_req_o;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_i);
      if (i2c.i2c_req_o && !prev) found = 1;
      prev = i2c.i2c_req_o;
    end
  endtask

  task automatic wait_done(output bit found);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_i);
      if (eng_done) found = 1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
  endtask

  initial begin
    exp_slot[0] = 16'd0;      exp_slot[1] = 16'd1;      exp_slot[2] = 16'd2;      exp_slot[3] = 16'd0;
    exp_line[0] = 16'd1;      exp_line[1] = 16'd1;      exp_line[2] = 16'd2;      exp_line[3] = 16'd1;
    exp_cmd[0]  = 16'hC040;   exp_cmd[1]  = 16'hC240;   exp_cmd[2]  = 16'hC040;   exp_cmd[3]  = 16'hC040;
    exp_data[0] = 16'h0640;   exp_data[1] = 16'h1900;   exp_data[2] = 16'h0050;   exp_data[3] = 16'h0640;

    rst_i = 1; enable_i = 0; eng_on = 1; inj_done = 0;
    hv_target_i = 12'd5; hv_limit_i = 12'd1600; ramp_period_i = 16'd0;
    thr_i = {12'd400, 12'd100}; eeprom_sel_i = 3'b010;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_req", i2c.i2c_req_o, 0);
    chk("rst_hv", hv_current_o, 0);
    chk("rst_at_target", at_target_o, 0);
    chk("rst_fault", i2c_fault_o, 0);
    chk("rst_slot", slot_o, 0);
    chk("rst_line", i2c.i2c_line_o, 0);
    chk("rst_cmd", i2c.i2c_cmd_o, 0);
    chk("rst_data", i2c.i2c_data_o, 0);

    // Slot rotation with a spurious done injected during the gap after slot 1
    enable_i = 1;
    rst_i = 0;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      chk("slot_req_seen", ok, 1);
      chk("slot_idx", slot_o, exp_slot[i]);
      chk("slot_line", i2c.i2c_line_o, exp_line[i]);
      chk("slot_cmd", i2c.i2c_cmd_o, exp_cmd[i]);
      chk("slot_data", i2c.i2c_data_o, exp_data[i]);
      if (i == 1) begin
        wait_done(ok);
        chk("slot1_done_seen", ok, 1);
        chk("slot1_cmd_stable", i2c.i2c_cmd_o, 16'hC240);
        chk("slot1_data_stable", i2c.i2c_data_o, 16'h1900);
        repeat (3) @(negedge clk_i);
        inj_done = 1;
        @(negedge clk_i);
        inj_done = 0;
      end
    end
    chk("slots_no_fault", i2c_fault_o, 0);

    // Reset while a transaction is pending, then restart at slot 0
    wait_req(ok);
    chk("mid_req_seen", ok, 1);
    chk("mid_slot", slot_o, 1);
    rst_i = 1;
    #1;
    chk("mid_rst_req", i2c.i2c_req_o, 0);
    chk("mid_rst_hv", hv_current_o, 0);
    repeat (3) @(negedge clk_i);
    chk("mid_rst_req_hold", i2c.i2c_req_o, 0);
    rst_i = 0;
    wait_req(ok);
    chk("restart_req_seen", ok, 1);
    chk("restart_slot", slot_o, 0);
    chk("restart_cmd", i2c.i2c_cmd_o, 16'hC040);
    chk("restart_data", i2c.i2c_data_o, 16'h0640);

    // Timeout: engine silent
    eng_on = 0;
    do_reset();
    cyc(41);
    chk("tmo_req_before", i2c.i2c_req_o, 1);
    chk("tmo_fault_before", i2c_fault_o, 0);
    cyc(1);
    chk("tmo_req_drop", i2c.i2c_req_o, 0);
    chk("tmo_fault_set", i2c_fault_o, 1);
    chk("tmo_slot_hold", slot_o, 0);
    cyc(8);
    chk("tmo_next_slot", slot_o, 1);
    chk("tmo_gap_req", i2c.i2c_req_o, 0);
    cyc(1);
    chk("tmo_next_req", i2c.i2c_req_o, 1);
    cyc(100);
    chk("tmo_fault_sticky", i2c_fault_o, 1);
    rst_i = 1;
    #1;
    chk("tmo_fault_clear", i2c_fault_o, 0);
    eng_on = 1;

    // Ramp up at period 4, then retarget down
    enable_i = 1; hv_target_i = 12'd1400; hv_limit_i = 12'd1600; ramp_period_i = 16'd4;
    do_reset();
    cyc(3);
    chk("ramp_hv_3", hv_current_o, 0);
    cyc(1);
    chk("ramp_hv_4", hv_current_o, 1);
    cyc(5595);
    chk("ramp_hv_5599", hv_current_o, 1399);
    chk("ramp_at_5599", at_target_o, 0);
    cyc(1);
    chk("ramp_hv_5600", hv_current_o, 1400);
    chk("ramp_at_5600", at_target_o, 1);
    hv_target_i = 12'd1300;
    cyc(3);
    chk("retgt_hv_hold", hv_current_o, 1400);
    chk("retgt_at", at_target_o, 0);
    cyc(1);
    chk("retgt_hv_dn1", hv_current_o, 1399);
    cyc(4);
    chk("retgt_hv_dn2", hv_current_o, 1398);

    // Period 0 steps every cycle; target above limit saturates at limit-1; disable ramps down
    hv_target_i = 12'd2000; hv_limit_i = 12'd1600; ramp_period_i = 16'd0;
    do_reset();
    cyc(1);
    chk("sat_hv_1", hv_current_o, 1);
    cyc(1597);
    chk("sat_hv_1598", hv_current_o, 1598);
    chk("sat_at_1598", at_target_o, 0);
    cyc(1);
    chk("sat_hv_1599", hv_current_o, 1599);
    chk("sat_at_1599", at_target_o, 1);
    cyc(50);
    chk("sat_hv_hold", hv_current_o, 1599);
    enable_i = 0;
    cyc(1);
    chk("dis_hv_first", hv_current_o, 1598);
    chk("dis_at", at_target_o, 0);
    cyc(1597);
    chk("dis_hv_1", hv_current_o, 1);
    cyc(1);
    chk("dis_hv_0", hv_current_o, 0);
    chk("dis_at_0", at_target_o, 1);
    cyc(5);
    chk("dis_hv_hold0", hv_current_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
